rs_kes_ibm: RTL and testbench

- Parametrised key-equation solver for the RS decoder. It uses an inversionless Berlekamp-Massey (iBM) algorithm, so no GF inverter is needed.
- Input: 2T syndromes from the syndrome block. Outputs: the error-locator polynomial Λ(x), the error-evaluator polynomial Ω(x), error count and fail flag, which feed Chien search and Forney.
- Replaces the fixed t=2 Euclid solver. Supports any T and takes a bus-style syndrome input.
- Built from the shared gf256mul instances; field arithmetic follows gf256mul.

---
 rtl/rs_kes_ibm.sv | 205 ++++++++++++++++++++
 tb/tb_rs_kes_ibm.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rs_kes_ibm.sv
// -----------------------------------------------------------------------------
// rs_kes_ibm -- key-equation solver for the RS decoder, inversionless
// Berlekamp-Massey. Produces a scaled error-locator Lambda(x) and a matching
// error-evaluator Omega(x) from 2T syndromes. Downstream, these feed Chien
// search and Forney.
//
// Ports
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   start      : request pulse, accepted only while busy=0
//   syndromes  : S1 in [M-1:0] ... S2T in the top M bits; latched on accept
//   busy       : solve in progress
//   done       : one-cycle pulse; results valid from this cycle and held
//   fail       : uncorrectable pattern (valid with done)
//   error_num  : final LFSR length L
//   elp        : Lambda0..LambdaT, Lambda0 in the LSBs (scaled, Lambda0 may be !=1)
//   evp        : Omega0..Omega(T-1), same scale factor as elp
//
// Field arithmetic uses the same GF(2^8) as gf256mul (x^8+x^4+x^3+x^2+1).
// -----------------------------------------------------------------------------
module rs_kes_ibm #(
    parameter int T  = 2,
    parameter int M  = 8,
    parameter int LW = $clog2(2*T+1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*T*M-1:0]     syndromes,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [LW-1:0]        error_num,
    output logic [(T+1)*M-1:0]   elp,
    output logic [T*M-1:0]       evp
);

    localparam int N  = 2*T + 1;
    localparam int RW = $clog2(2*T + 1);
    localparam int IW = (T > 1) ? $clog2(T) : 1;

    typedef enum logic [2:0] {IDLE, DISC, UPD, OMEGA, FIN} state_t;

    state_t         state_reg, state_next;
    logic [M-1:0]   lam_reg [N];
    logic [M-1:0]   b_reg   [N];
    logic [M-1:0]   syn_reg [2*T];
    logic [M-1:0]   omg_reg [T];
    logic [M-1:0]   gamma_reg, delta_reg;
    logic [LW-1:0]  l_reg;
    logic [RW-1:0]  r_reg;
    logic [IW-1:0]  oi_reg;

    logic [M-1:0]   mul_p   [N];
    logic [M-1:0]   lam_upd [N];
    logic [M-1:0]   disc_sum;
    logic           load_en, swap, fail_calc;
    int             kk_int;

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] p;
        logic [M-1:0] aa;
        p  = '0;
        aa = a;
        for (int k = 0; k < M; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[M-2:0], 1'b0} ^ (aa[M-1] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    // Shared multiplier array. Multiplier gi pairs Lambda_gi with S(kk+1-gi);
    // kk is r during DISC (discrepancy) and the Omega index during OMEGA.
    always_comb kk_int = (state_reg == OMEGA) ? int'(oi_reg) : int'(r_reg);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_disc
            logic [M-1:0] b_sel;
            always_comb begin
                b_sel = '0;
                for (int m = 0; m < 2*T; m++)
                    if (m + gi == kk_int) b_sel = syn_reg[m];
            end
            assign mul_p[gi] = gf_mul(lam_reg[gi], b_sel);
        end

        // Lambda <- gamma*Lambda + delta*x*B
        for (gi = 0; gi < N; gi++) begin : g_upd
            if (gi == 0) begin : g_lo
                assign lam_upd[gi] = gf_mul(gamma_reg, lam_reg[gi]);
            end else begin : g_hi
                assign lam_upd[gi] = gf_mul(gamma_reg, lam_reg[gi]) ^ gf_mul(delta_reg, b_reg[gi-1]);
            end
        end
    endgenerate

    always_comb begin
        disc_sum = '0;
        for (int k = 0; k < N; k++) disc_sum = disc_sum ^ mul_p[k];
    end

    assign swap = (delta_reg != '0) && (2 * int'(l_reg) <= int'(r_reg));

    // Degree check runs over all 2T+1 coefficients, not just the exported ones.
    always_comb begin
        fail_calc = (int'(l_reg) > T);
        for (int k = 0; k < N; k++) begin
            if (k == int'(l_reg) && lam_reg[k] == '0) fail_calc = 1'b1;
            if (k > int'(l_reg) && lam_reg[k] != '0) fail_calc = 1'b1;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = (syndromes == '0) ? FIN : DISC;
            DISC:    state_next = UPD;
            UPD:     state_next = (int'(r_reg) == 2*T - 1) ? OMEGA : DISC;
            OMEGA:   if (int'(oi_reg) == T - 1) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy    = (state_reg != IDLE);
        load_en = (state_reg == IDLE) && start;
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                lam_reg[k] <= '0;
                b_reg[k]   <= '0;
            end
            for (int k = 0; k < 2*T; k++) syn_reg[k] <= '0;
            for (int k = 0; k < T; k++)   omg_reg[k] <= '0;
            gamma_reg <= '0;
            delta_reg <= '0;
            l_reg     <= '0;
            r_reg     <= '0;
            oi_reg    <= '0;
            done      <= 1'b0;
            fail      <= 1'b0;
            error_num <= '0;
            elp       <= '0;
            evp       <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (load_en) begin
                        for (int k = 0; k < 2*T; k++) syn_reg[k] <= syndromes[k*M +: M];
                        for (int k = 0; k < N; k++) begin
                            lam_reg[k] <= (k == 0) ? M'(1) : '0;
                            b_reg[k]   <= (k == 0) ? M'(1) : '0;
                        end
                        for (int k = 0; k < T; k++) omg_reg[k] <= '0;
                        gamma_reg <= M'(1);
                        l_reg     <= '0;
                        r_reg     <= '0;
                        oi_reg    <= '0;
                    end
                end
                DISC: delta_reg <= disc_sum;
                UPD: begin
                    for (int k = 0; k < N; k++) lam_reg[k] <= lam_upd[k];
                    if (swap) begin
                        for (int k = 0; k < N; k++) b_reg[k] <= lam_reg[k];
                        l_reg     <= LW'(int'(r_reg) + 1 - int'(l_reg));
                        gamma_reg <= delta_reg;
                    end else begin
                        b_reg[0] <= '0;
                        for (int k = 1; k < N; k++) b_reg[k] <= b_reg[k-1];
                    end
                    r_reg <= r_reg + 1'b1;
                end
                OMEGA: begin
                    for (int k = 0; k < T; k++)
                        if (k == int'(oi_reg)) omg_reg[k] <= disc_sum;
                    oi_reg <= oi_reg + 1'b1;
                end
                FIN: begin
                    for (int k = 0; k <= T; k++) elp[k*M +: M] <= lam_reg[k];
                    for (int k = 0; k < T; k++)  evp[k*M +: M] <= omg_reg[k];
                    error_num <= l_reg;
                    fail      <= fail_calc;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_kes_ibm.sv
module tb_rs_kes_ibm;

    localparam int T  = 2;
    localparam int M  = 8;
    localparam int LW = $clog2(2*T+1);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [2*T*M-1:0]     syndromes = '0;
    logic                 busy, done, fail;
    logic [LW-1:0]        error_num;
    logic [(T+1)*M-1:0]   elp;
    logic [T*M-1:0]       evp;

    rs_kes_ibm #(.T(T), .M(M), .LW(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .syndromes (syndromes),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .error_num (error_num),
        .elp       (elp),
        .evp       (evp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string          name;
        logic [31:0]    syn;
        logic [23:0]    elp;
        logic [15:0]    evp;
        logic [LW-1:0]  num;
        logic           fail;
        int             lat;
    } vec_t;

    typedef struct {
        string          name;
        logic [23:0]    elp;
        logic [15:0]    evp;
        logic [LW-1:0]  num;
        logic           fail;
        int             due;
    } exp_t;

    vec_t vecs [6];
    exp_t sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: done seen at cycle %0d with empty scoreboard", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_elp"},  64'(elp),       64'(e.elp));
                check({e.name, "_evp"},  64'(evp),       64'(e.evp));
                check({e.name, "_num"},  64'(error_num), 64'(e.num));
                check({e.name, "_fail"}, 64'(fail),      64'(e.fail));
                check({e.name, "_lat"},  64'(cyc),       64'(e.due));
                check({e.name, "_busy_low"}, 64'(busy),  64'(0));
                $display("[TB] %s: elp=%h evp=%h L=%0d fail=%0d at cycle %0d", e.name, elp, evp, error_num, fail, cyc);
            end
        end
    end

    // Drive one start from the current (negedge) position; optionally queue its result.
    task automatic apply(input vec_t v, input bit accept);
        exp_t e;
        start     = 1'b1;
        syndromes = v.syn;
        @(posedge clk);
        #1;
        start     = 1'b0;
        syndromes = $urandom;
        check({v.name, "_busy"}, 64'(busy), 64'(1));
        if (accept) begin
            e.name = v.name;
            e.elp  = v.elp;
            e.evp  = v.evp;
            e.num  = v.num;
            e.fail = v.fail;
            e.due  = cyc + v.lat;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("drain", 64'(sb.size()), 64'(0));
        sb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t ign_a, ign_b;
        int   snap;

        //        name       syndromes     elp         evp        L     fail lat
        vecs[0] = '{"zero",   32'h00000000, 24'h000001, 16'h0000, 3'd0, 1'b0, 1};
        vecs[1] = '{"err1_x1",32'h01010101, 24'h000101, 16'h0001, 3'd1, 1'b0, 11};
        vecs[2] = '{"degfail",32'h00000001, 24'h000001, 16'h0001, 3'd1, 1'b1, 11};
        vecs[3] = '{"lgtt",   32'h01000000, 24'h000001, 16'h0000, 3'd4, 1'b1, 11};
        vecs[4] = '{"err1_x2",32'h10080402, 24'h001008, 16'h0010, 3'd1, 1'b0, 11};
        vecs[5] = '{"err2",   32'h11090503, 24'h446622, 16'h0066, 3'd2, 1'b0, 11};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_outs", 64'({done, fail, error_num, elp, evp}), 64'(0));
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            apply(vecs[i], 1'b1);
            wait_drain();
        end

        // Starts while busy are ignored; a start in the done cycle is accepted.
        ign_a = vecs[3];
        ign_b = vecs[5];
        @(negedge clk);
        apply(vecs[1], 1'b1);
        repeat (3) @(negedge clk);
        apply(ign_a, 1'b0);
        repeat (4) @(negedge clk);
        apply(ign_b, 1'b0);
        begin
            int k;
            for (k = 0; k < 20 && !done; k++) @(negedge clk);
            check("busy_seq_done_seen", 64'(done), 64'(1));
        end
        apply(vecs[5], 1'b1);
        wait_drain();

        // Reset mid-solve aborts without a done pulse
        @(negedge clk);
        apply(vecs[1], 1'b0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_outs", 64'({done, fail, error_num, elp, evp}), 64'(0));
        snap = done_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_done", 64'(done_cnt), 64'(snap));
        @(negedge clk);
        apply(vecs[1], 1'b1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
